// File: rtl/ps2_key_serializer.sv
// PS/2 keyboard-side transmitter: turns hps_io key events into scan-code-set-2
// byte sequences, queues them and clocks them out on open-drain clk/data lines.
module ps2_key_serializer #(
    parameter int HALF_BIT = 1145,
    parameter int IDLE_GAP = 2290,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_out,
    output logic        ps2_data_out,
    output logic        busy,
    output logic        overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2((IDLE_GAP > HALF_BIT) ? IDLE_GAP : HALF_BIT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, BIT_HIGH, BIT_LOW} state_t;

    state_t             state;
    logic               clk_meta, clk_sync, data_meta, data_sync;
    logic               init_done, last_toggle;
    logic [1:0]         seq_left;
    logic [7:0]         seq_b0, seq_b1, seq_b2;
    logic [1:0]         new_len;
    logic [7:0]         new_b0, new_b1, new_b2;
    logic               new_event, fits, push, pop;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW+1:0] need;
    logic [7:0]         head;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         bit_idx;
    logic [10:0]        frame;

    // Two-flop synchronisers for the sensed bus lines (idle level is high)
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    // Byte sequence and length for the event currently presented on ps2_key
    always_comb begin
        new_len = 2'd1;
        new_b0  = ps2_key[7:0];
        new_b1  = 8'h00;
        new_b2  = 8'h00;
        case ({ps2_key[8], ~ps2_key[9]})
            2'b01: begin new_len = 2'd2; new_b0 = 8'hF0; new_b1 = ps2_key[7:0]; end
            2'b10: begin new_len = 2'd2; new_b0 = 8'hE0; new_b1 = ps2_key[7:0]; end
            2'b11: begin
                new_len = 2'd3; new_b0 = 8'hE0; new_b1 = 8'hF0; new_b2 = ps2_key[7:0];
            end
            default: ;
        endcase
    end

    assign new_event = init_done && (ps2_key[10] != last_toggle);
    assign need      = {1'b0, count} + {{FIFO_AW{1'b0}}, new_len};
    assign fits      = (need <= (FIFO_AW + 2)'(DEPTH));
    assign push      = (seq_left != 2'd0);
    assign pop       = (state == BIT_LOW) && (bit_idx == 4'd10) && (cnt == CNT_W'(HALF_BIT - 1));
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);

    // Event capture: accept whole sequences only, then feed one byte per cycle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            init_done   <= 1'b0;
            last_toggle <= 1'b0;
            seq_left    <= 2'd0;
            seq_b0      <= 8'h00;
            seq_b1      <= 8'h00;
            seq_b2      <= 8'h00;
            overflow    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (!init_done) begin
                init_done   <= 1'b1;
                last_toggle <= ps2_key[10];
            end
            if (new_event) begin
                last_toggle <= ps2_key[10];
                if (fits) begin
                    seq_left <= new_len;
                    seq_b0   <= new_b0;
                    seq_b1   <= new_b1;
                    seq_b2   <= new_b2;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (seq_left != 2'd0) begin
                seq_b0   <= seq_b1;
                seq_b1   <= seq_b2;
                seq_left <= seq_left - 2'd1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= seq_b0;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Frame transmitter: wait for a quiet bus, shift 11 bits, retry on inhibit
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= 4'd0;
            frame        <= 11'h7FF;
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ps2_clk_out  <= 1'b1;
                    ps2_data_out <= 1'b1;
                    cnt          <= '0;
                    if (count != '0) state <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!clk_sync || !data_sync) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(IDLE_GAP - 1)) begin
                        frame        <= {1'b1, ~^head, head, 1'b0};
                        bit_idx      <= 4'd0;
                        cnt          <= '0;
                        ps2_data_out <= 1'b0;
                        state        <= BIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if ((bit_idx <= 4'd9) && (cnt >= CNT_W'(3)) && !clk_sync) begin
                        ps2_clk_out  <= 1'b1;
                        ps2_data_out <= 1'b1;
                        cnt          <= '0;
                        state        <= WAIT_IDLE;
                    end else if (cnt == CNT_W'(HALF_BIT - 1)) begin
                        ps2_clk_out <= 1'b0;
                        cnt         <= '0;
                        state       <= BIT_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_LOW: begin
                    if (cnt == CNT_W'(HALF_BIT - 1)) begin
                        cnt         <= '0;
                        ps2_clk_out <= 1'b1;
                        if (bit_idx == 4'd10) begin
                            ps2_data_out <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            bit_idx      <= bit_idx + 4'd1;
                            ps2_data_out <= frame[bit_idx + 4'd1];
                            state        <= BIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench for ps2_key_serializer: models the host side of the PS/2 bus,
// decodes frames on falling clock edges and checks bytes, timing and inhibit.
module tb_ps2_key_serializer;

    localparam int HALF_BIT = 20;
    localparam int IDLE_GAP = 40;
    localparam int FIFO_AW  = 4;
    localparam int MIN_GAP  = 2 * HALF_BIT + IDLE_GAP;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b0;
    logic [10:0] ps2_key   = 11'h000;
    logic        host_clk  = 1'b1;
    logic        host_data = 1'b1;
    logic        ps2_clk_in, ps2_data_in;
    logic        ps2_clk_out, ps2_data_out, busy, overflow;

    int checks   = 0;
    int failures = 0;

    int          cyc        = 0;
    int          ov_count   = 0;
    logic [10:0] rx_shift   = 11'h000;
    logic [10:0] last_frame = 11'h000;
    int          rx_bits    = 0;
    int          edge_total = 0;
    int          frame_errs = 0;
    int          end_cyc    = 0;
    bit          have_end   = 1'b0;
    logic [7:0]  rx_q [$];
    int          gap_q [$];

    assign ps2_clk_in  = ps2_clk_out & host_clk;
    assign ps2_data_in = ps2_data_out & host_data;

    ps2_key_serializer #(
        .HALF_BIT (HALF_BIT),
        .IDLE_GAP (IDLE_GAP),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_key      (ps2_key),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .busy         (busy),
        .overflow     (overflow)
    );

    // Free-running system clock
    always #5 clk_sys = ~clk_sys;

    // Cycle counter and overflow pulse counter
    always @(posedge clk_sys) begin
        cyc++;
        if (overflow) ov_count++;
    end

    // Host receiver: samples data on device-driven falling clock edges; a host
    // inhibit or a reset throws away any partial frame
    always @(negedge ps2_clk_in or negedge host_clk or negedge reset_n) begin
        if (!reset_n || !host_clk) begin
            rx_bits = 0;
        end else if (!ps2_clk_in) begin
            rx_shift = {ps2_data_in, rx_shift[10:1]};
            rx_bits++;
            edge_total++;
            if (rx_bits == 1 && have_end) gap_q.push_back(cyc - end_cyc);
            if (rx_bits == 11) begin
                rx_q.push_back(rx_shift[8:1]);
                last_frame = rx_shift;
                if (rx_shift[0] != 1'b0 || rx_shift[10] != 1'b1 || ^rx_shift[9:1] != 1'b1)
                    frame_errs++;
                end_cyc  = cyc;
                have_end = 1'b1;
                rx_bits  = 0;
            end
        end
    end

    // Absolute time limit so the run always ends
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic pressed, input logic ext, input logic [7:0] code);
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_not_busy(input int budget, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check_output({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_rx_bits(input int target, input int budget, input string tag);
        int n = 0;
        while (rx_bits < target && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check_output(tag, 32'(rx_bits >= target), 32'd1);
    endtask

    initial begin
        int base, gbase, e0, ov0, bad, errs, min_gap;
        logic [7:0] exp_b, code;

        $display("[TB] start");

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_output("rst_clk_out",  32'(ps2_clk_out),  32'd1);
        check_output("rst_data_out", 32'(ps2_data_out), 32'd1);
        check_output("rst_busy",     32'(busy),         32'd0);
        check_output("rst_overflow", 32'(overflow),     32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        // Press 'A' (1C): single frame 0,0,0,1,1,1,0,0,0,0,1
        base = rx_q.size();
        e0   = edge_total;
        apply_stimulus(1'b1, 1'b0, 8'h1C);
        repeat (3) @(negedge clk_sys);
        check_output("press_a_busy", 32'(busy), 32'd1);
        wait_not_busy(2000, "press_a");
        check_output("press_a_count", 32'(rx_q.size() - base), 32'd1);
        check_output("press_a_byte",  32'(rx_q[base]), 32'h1C);
        check_output("press_a_bits",  32'(last_frame), 32'(11'b10000111000));
        check_output("press_a_edges", 32'(edge_total - e0), 32'd11);

        // Extended release of 75: E0, F0, 75 with idle gaps between frames
        base  = rx_q.size();
        gbase = gap_q.size();
        apply_stimulus(1'b0, 1'b1, 8'h75);
        repeat (5) @(negedge clk_sys);
        wait_not_busy(4000, "ext_rel");
        check_output("ext_rel_count", 32'(rx_q.size() - base), 32'd3);
        check_output("ext_rel_b0", 32'(rx_q[base]),     32'hE0);
        check_output("ext_rel_b1", 32'(rx_q[base + 1]), 32'hF0);
        check_output("ext_rel_b2", 32'(rx_q[base + 2]), 32'h75);
        min_gap = 1_000_000;
        for (int i = gbase; i < gap_q.size(); i++)
            if (gap_q[i] < min_gap) min_gap = gap_q[i];
        check_output("ext_rel_gap", 32'((gap_q.size() - gbase >= 2) && (min_gap >= MIN_GAP)), 32'd1);

        // Host inhibit during data bit 4 of 1C: lines released, byte retried once
        base = rx_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h1C);
        wait_rx_bits(5, 2000, "inhibit_reach");
        host_clk = 1'b0;
        repeat (HALF_BIT + 4) @(negedge clk_sys);
        bad = 0;
        repeat (300) begin
            @(negedge clk_sys);
            if (!(ps2_clk_out === 1'b1 && ps2_data_out === 1'b1)) bad++;
        end
        check_output("inhibit_released", 32'(bad), 32'd0);
        check_output("inhibit_busy", 32'(busy), 32'd1);
        host_clk = 1'b1;
        wait_not_busy(2000, "inhibit");
        check_output("inhibit_count", 32'(rx_q.size() - base), 32'd1);
        check_output("inhibit_byte",  32'(rx_q[base]), 32'h1C);

        // Overflow: 8 ext releases while the host holds clk low; 5 fit (15 bytes)
        base     = rx_q.size();
        ov0      = ov_count;
        host_clk = 1'b0;
        repeat (5) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            code = 8'h10 + 8'(i);
            apply_stimulus(1'b0, 1'b1, code);
            repeat (10) @(negedge clk_sys);
        end
        check_output("ovf_pulses", 32'(ov_count - ov0), 32'd3);
        check_output("ovf_busy", 32'(busy), 32'd1);
        host_clk = 1'b1;
        wait_not_busy(15000, "ovf");
        check_output("ovf_count", 32'(rx_q.size() - base), 32'd15);
        errs = 0;
        for (int e = 0; e < 5; e++) begin
            for (int k = 0; k < 3; k++) begin
                exp_b = (k == 0) ? 8'hE0 : (k == 1) ? 8'hF0 : 8'h10 + 8'(e);
                if (rx_q[base + 3 * e + k] !== exp_b) errs++;
            end
        end
        check_output("ovf_sequence", 32'(errs), 32'd0);

        // Reset during data bit 6: immediate release, nothing sent afterwards
        base = rx_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h1C);
        wait_rx_bits(7, 2000, "reset_reach");
        repeat (2) @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        #1;
        check_output("midrst_clk_out",  32'(ps2_clk_out),  32'd1);
        check_output("midrst_data_out", 32'(ps2_data_out), 32'd1);
        check_output("midrst_busy",     32'(busy),         32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        bad = 0;
        repeat (600) begin
            @(negedge clk_sys);
            if (busy !== 1'b0) bad++;
        end
        check_output("postrst_no_busy",   32'(bad), 32'd0);
        check_output("postrst_no_frames", 32'(rx_q.size() - base), 32'd0);

        // Press then release 1C ten cycles apart
        base = rx_q.size();
        ov0  = ov_count;
        apply_stimulus(1'b1, 1'b0, 8'h1C);
        repeat (10) @(negedge clk_sys);
        apply_stimulus(1'b0, 1'b0, 8'h1C);
        repeat (5) @(negedge clk_sys);
        wait_not_busy(5000, "b2b");
        check_output("b2b_count", 32'(rx_q.size() - base), 32'd3);
        check_output("b2b_b0", 32'(rx_q[base]),     32'h1C);
        check_output("b2b_b1", 32'(rx_q[base + 1]), 32'hF0);
        check_output("b2b_b2", 32'(rx_q[base + 2]), 32'h1C);
        check_output("b2b_no_ovf", 32'(ov_count - ov0), 32'd0);

        // Every received frame had a valid start, odd parity and stop bit
        check_output("frame_format", 32'(frame_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
